// File: rtl/etapa_fetch.sv
// Instruction fetch stage: requests one word per PC, holds it until consumed, then advances or branches.
// Optional FETCH_STALL_CNT_EN adds stall_cnt, a saturating count of REQ cycles without imem_ack.
module etapa_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instr_out,
   output logic [15:0] imm_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        valid,
   input  logic        ready,
   input  logic        branch_en,
   input  logic [31:0] branch_target
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic        fetch_done;
   logic        consume;

   assign fetch_done = (state == REQ) && imem_ack;
   assign consume    = (state == HOLD) && ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Enable is only sampled when leaving IDLE or HOLD, so a fetch in flight always completes.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = REQ;
         REQ:     if (imem_ack) state_nxt = HOLD;
         HOLD:    if (ready) state_nxt = enable ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state == REQ);
      valid     = (state == HOLD);
      imem_addr = pc;
      imm_out   = instr_out[15:0];
      pc_plus4  = pc_out + 32'd4;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= RESET_PC;
         pc_out    <= RESET_PC;
         instr_out <= '0;
      end else begin
         if (fetch_done) begin
            instr_out <= imem_data;
            pc_out    <= pc;
         end
         // Branch targets are forced word-aligned; sequential increment wraps naturally at 2^32.
         if (consume)
            pc <= branch_en ? (branch_target & 32'hFFFF_FFFC) : pc_out + 32'd4;
      end
   end

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if ((state == REQ) && !imem_ack && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_etapa_fetch.sv
// Self-checking bench for etapa_fetch: directed table, reset corner cases, randomized transactions.
// Drives and samples on the falling clock edge; stall counter checks compile only with FETCH_STALL_CNT_EN.
module tb_etapa_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr_out;
   logic [15:0] imm_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        valid;
   logic        ready;
   logic        branch_en;
   logic [31:0] branch_target;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   etapa_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .instr_out     (instr_out),
      .imm_out       (imm_out),
      .pc_out        (pc_out),
      .pc_plus4      (pc_plus4),
      .valid         (valid),
      .ready         (ready),
      .branch_en     (branch_en),
      .branch_target (branch_target)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          ack_delay;
      int          hold;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] exp_addr;
      logic [31:0] exp_plus4;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!imem_req && n < budget) begin
         tick();
         n++;
      end
      chk("req_timeout", {31'd0, imem_req}, 32'd1);
   endtask

   // One fetch: await the request, stall ack_delay cycles, return data, check the held outputs.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                        input int ack_delay, input bit drop_en);
      logic [15:0] exp_imm;
      exp_imm = data[15:0];
      wait_req(20);
      chk("fetch_addr", imem_addr, exp_addr);
      if (drop_en) enable = 1'b0;
      for (int i = 0; i < ack_delay; i++) begin
         branch_en     = 1'($urandom);
         branch_target = $urandom;
         tick();
         chk("req_held", {31'd0, imem_req}, 32'd1);
         chk("addr_held", imem_addr, exp_addr);
      end
      branch_en = 1'b0;
      imem_ack  = 1'b1;
      imem_data = data;
      tick();
      imem_ack  = 1'b0;
      imem_data = $urandom;
      chk("valid_rise", {31'd0, valid}, 32'd1);
      chk("req_low_hold", {31'd0, imem_req}, 32'd0);
      chk("instr_out", instr_out, data);
      chk("imm_out", {16'd0, imm_out}, {16'd0, exp_imm});
      chk("pc_out", pc_out, exp_addr);
      chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
   endtask

   // Stall in HOLD with ready low; stray acks and branch requests must be ignored.
   task automatic hold(input int n, input logic [31:0] exp_addr, input logic [31:0] data);
      for (int i = 0; i < n; i++) begin
         imem_ack      = 1'($urandom);
         imem_data     = $urandom;
         branch_en     = 1'($urandom);
         branch_target = $urandom;
         tick();
         chk("hold_valid", {31'd0, valid}, 32'd1);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
         chk("hold_instr", instr_out, data);
         chk("hold_pc", pc_out, exp_addr);
      end
      imem_ack  = 1'b0;
      branch_en = 1'b0;
   endtask

   task automatic consume(input logic br, input logic [31:0] tgt, input logic en,
                          input logic [31:0] exp_next);
      ready         = 1'b1;
      branch_en     = br;
      branch_target = tgt;
      enable        = en;
      tick();
      ready     = 1'b0;
      branch_en = 1'b0;
      chk("valid_clear", {31'd0, valid}, 32'd0);
      chk("req_after_consume", {31'd0, imem_req}, {31'd0, en});
      if (en) chk("next_addr", imem_addr, exp_next);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      imem_ack = 1'b0;
      ready = 1'b0;
      branch_en = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_addr;
      logic [31:0] nxt;
      logic [31:0] data;
      logic [31:0] tgt;
      logic        br;
      logic        en;

      vecs[0] = '{32'h2008_FFFE, 0, 5, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
      vecs[1] = '{32'h1234_5678, 1, 1, 1'b1, 32'h0000_0103, 32'h0000_0004, 32'h0000_0008, 32'h0000_0100};
      vecs[2] = '{32'h8C01_0004, 2, 0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFFC};
      vecs[3] = '{32'hDEAD_BEEF, 0, 2, 1'b0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
      vecs[4] = '{32'h0000_8001, 3, 0, 1'b1, 32'h0000_0042, 32'h0000_0000, 32'h0000_0004, 32'h0000_0040};

      imem_data = '0;
      branch_target = '0;
      do_reset();
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_instr", instr_out, 32'd0);
      chk("rst_imm", {16'd0, imm_out}, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_pc_plus4", pc_plus4, 32'd4);

      reset  = 1'b0;
      enable = 1'b1;
      foreach (vecs[i]) begin
         fetch(vecs[i].exp_addr, vecs[i].data, vecs[i].ack_delay, 1'b0);
         chk("tbl_plus4", pc_plus4, vecs[i].exp_plus4);
         hold(vecs[i].hold, vecs[i].exp_addr, vecs[i].data);
         consume(vecs[i].br, vecs[i].tgt, 1'b1, vecs[i].exp_next);
      end

      // Reset coinciding with imem_ack: the fetch at 0x40 is dropped.
      wait_req(20);
      chk("pre_rst_addr", imem_addr, 32'h0000_0040);
      imem_ack  = 1'b1;
      imem_data = 32'hCAFE_F00D;
      reset     = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("ackrst_valid", {31'd0, valid}, 32'd0);
      chk("ackrst_req", {31'd0, imem_req}, 32'd0);
      chk("ackrst_instr", instr_out, 32'd0);
      chk("ackrst_pc_out", pc_out, 32'd0);
      tick();
      chk("ackrst_idle_req", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      fetch(32'h0000_0000, 32'h1111_2222, 1, 1'b0);
      consume(1'b0, 32'd0, 1'b1, 32'h0000_0004);

      // Reset in HOLD together with ready: the held instruction is discarded.
      fetch(32'h0000_0004, 32'h3333_4444, 0, 1'b0);
      ready = 1'b1;
      reset = 1'b1;
      tick();
      ready = 1'b0;
      chk("holdrst_valid", {31'd0, valid}, 32'd0);
      chk("holdrst_pc_out", pc_out, 32'd0);
      chk("holdrst_instr", instr_out, 32'd0);
      reset = 1'b0;
      exp_addr = 32'h0000_0000;

      // Randomized transactions against an address-sequence model.
      for (int t = 0; t < 60; t++) begin
         data = $urandom;
         br   = 1'($urandom);
         tgt  = $urandom;
         en   = ($urandom_range(0, 2) != 0);
         nxt  = br ? (tgt & 32'hFFFF_FFFC) : exp_addr + 32'd4;
         fetch(exp_addr, data, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
         hold($urandom_range(0, 3), exp_addr, data);
         consume(br, tgt, en, nxt);
         if (!en) begin
            for (int k = 0; k < $urandom_range(1, 3); k++) begin
               imem_ack = 1'($urandom);
               tick();
               chk("idle_req", {31'd0, imem_req}, 32'd0);
               chk("idle_valid", {31'd0, valid}, 32'd0);
            end
            imem_ack = 1'b0;
            enable   = 1'b1;
         end
         exp_addr = nxt;
      end

`ifdef FETCH_STALL_CNT_EN
      do_reset();
      chk("stall_rst", {16'd0, stall_cnt}, 32'd0);
      reset  = 1'b0;
      enable = 1'b1;
      fetch(32'h0000_0000, 32'hAAAA_0001, 3, 1'b0);
      consume(1'b0, 32'd0, 1'b1, 32'h0000_0004);
      fetch(32'h0000_0004, 32'hAAAA_0002, 3, 1'b0);
      chk("stall_six", {16'd0, stall_cnt}, 32'd6);
      consume(1'b0, 32'd0, 1'b1, 32'h0000_0008);
      repeat (65540) tick();
      chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/etapa_fetch.md
ETAPA_FETCH -- requirements
Module: etapa_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port enable  input  1  SHALL permit new fetches while high.
REQ-005 Port imem_req  output  1  SHALL request a read from instruction memory.
REQ-006 Port imem_addr  output  32  SHALL carry the current PC while imem_req is high.
REQ-007 Port imem_ack  input  1  SHALL mark imem_data valid for one cycle.
REQ-008 Port imem_data  input  32  SHALL be the fetched instruction word.
REQ-009 Port instr_out  output  32  SHALL be the registered fetched instruction.
REQ-010 Port imm_out  output  16  SHALL equal instr_out[15:0], the immediate field for the sign-extension stage.
REQ-011 Port pc_out  output  32  SHALL be the address of instr_out.
REQ-012 Port pc_plus4  output  32  SHALL equal pc_out + 4, modulo 2^32.
REQ-013 Port valid  output  1  SHALL mark instr_out, imm_out and pc_out as holding a fetched instruction.
REQ-014 Port ready  input  1  SHALL mean that downstream consumes the instruction this cycle.
REQ-015 Port branch_en  input  1  SHALL select branch_target as the next PC on consumption.
REQ-016 Port branch_target  input  32  SHALL be the redirect address.

Function
REQ-017 FSM states SHALL be IDLE, REQ and HOLD.
- IDLE: imem_req=0, valid=0; if enable=1, go to REQ.
- REQ: imem_req=1, imem_addr=pc; on imem_ack=1, latch imem_data into instr_out, latch pc into pc_out, set valid=1, go to HOLD.
- HOLD: valid=1, imem_req=0; when ready=1, clear valid and advance pc; go to REQ if enable=1, else to IDLE.
REQ-018 Latency: valid SHALL rise on the cycle after the imem_ack cycle.
REQ-019 On consumption (HOLD and ready=1), pc SHALL become {branch_target[31:2],2'b00} if branch_en=1, else pc_out + 4.
REQ-020 branch_en SHALL be ignored in any cycle that is not a consumption cycle.
REQ-021 PC increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-022 Deasserting enable while in REQ SHALL NOT abort the outstanding request; the FSM SHALL finish the fetch.
REQ-023 instr_out, imm_out and pc_out SHALL stay stable while valid=1 and ready=0.
REQ-024 imem_ack SHALL be ignored outside REQ.
REQ-025 All outputs SHALL be registered or decoded directly from registered state.

Reset
REQ-026 While reset=1, state SHALL be IDLE, pc=RESET_PC, imem_req=0, valid=0, instr_out=0, pc_out=RESET_PC, and imm_out=0.
REQ-027 If reset occurs mid-fetch or while in HOLD, the pending fetch or instruction SHALL be discarded; reset SHALL win over a simultaneous imem_ack or ready.

Configuration
REQ-028 With macro FETCH_STALL_CNT_EN defined, the module SHALL add output stall_cnt[15:0].
- stall_cnt counts cycles spent in REQ with imem_ack=0.
- It saturates at 16'hFFFF.
- reset clears it to 0.
REQ-029 Without FETCH_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Verification
REQ-030 Reset release with enable=1 and imem_ack returned one cycle after imem_req, imem_data=32'h2008_FFFE -> imem_addr=0, then valid=1, instr_out=32'h2008_FFFE, imm_out=16'hFFFE, pc_out=0, pc_plus4=4.
REQ-031 ready held 0 for 5 cycles in HOLD -> outputs stable and imem_req=0 throughout; ready=1 -> next imem_addr=4.
REQ-032 Consumption with branch_en=1 and branch_target=32'h0000_0103 -> next imem_addr=32'h0000_0100; branch_en=1 while in REQ -> no effect.
REQ-033 PC at 32'hFFFF_FFFC consumed with branch_en=0 -> next imem_addr=0 and pc_plus4=0.
REQ-034 reset asserted in the same cycle as imem_ack -> valid=0, imem_req=0, state IDLE, pc=RESET_PC.
REQ-035 With FETCH_STALL_CNT_EN defined, imem_ack delayed 3 cycles on each of two fetches -> stall_cnt=6; a forced long stall saturates the counter at 16'hFFFF.
